fsm_ctrl_multi: RTL and testbench
=================================

Name: fsm_ctrl_multi

Overview:
- Parametrised successor of the flow-control FSM for the PCIe-style switch datapath.
- Generalises the fixed five-FIFO / mixed-width threshold controller to NUM_FIFOS channels of uniform UMB_W-bit thresholds.
- Adds the following, which the earlier controller does not have:
  - sticky per-FIFO error source capture;
  - threshold lock outside INIT;
  - a programmable ACTIVE->IDLE drain hysteresis.
- Sits between the configuration interface (init, thresholds) and the FIFO bank, which consumes umbrales_out as almost-full/almost-empty levels.

Parameters:
- NUM_FIFOS, 5, number of FIFOs monitored (>=1).
- UMB_W, 4, width of each FIFO threshold field (>=1).
- IDLE_WAIT, 2, consecutive all-empty cycles required in ACTIVE before entering IDLE (>=1).

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  requests (re)initialisation / threshold load.
- umbral_in  in  NUM_FIFOS*UMB_W  thresholds; FIFO k at bits [k*UMB_W +: UMB_W].
- fifo_error  in  NUM_FIFOS  per-FIFO overflow/underflow flag.
- fifo_empty  in  NUM_FIFOS  per-FIFO empty flag.
- umbrales_out  out  NUM_FIFOS*UMB_W  thresholds latched for the FIFO bank.
- active  out  1  high in ACTIVE.
- idle  out  1  high in IDLE.
- error  out  1  high in ERROR.
- error_src  out  NUM_FIFOS  sticky record of FIFOs that raised fifo_error.
- state  out  3  current state encoding (debug).

Behaviour:
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Codes 5-7 are illegal and go to RESET on the next clock.
- reset=1 (async, any time, including mid-ACTIVE or mid-ERROR):
  - state=RESET, umbrales_out=0, error_src=0, drain counter=0;
  - active, idle and error all 0.
- Outputs active, idle and error are decoded from the state register only (Moore). They change in the same cycle the state changes and are never combinationally dependent on inputs.
- RESET: first rising edge with reset=0 -> INIT, unconditionally.
- INIT:
  - Every edge while in INIT: umbrales_out <= umbral_in, and error_src <= 0.
  - init=1 -> stay INIT; init=0 -> IDLE.
  - fifo_error is ignored in INIT.
  - The value loaded on the exiting edge is the one retained.
- Threshold lock: outside INIT, umbrales_out holds; umbral_in changes have no effect.
- IDLE, evaluated in priority order:
  - |fifo_error -> ERROR;
  - else init -> INIT;
  - else any fifo_empty bit = 0 -> ACTIVE;
  - else stay.
- ACTIVE, evaluated in priority order:
  - |fifo_error -> ERROR;
  - else init -> INIT;
  - else drain counter logic (below).
- Drain counter, width clog2(IDLE_WAIT+1):
  - In ACTIVE with all fifo_empty=1, the counter increments.
  - Any non-empty FIFO clears it to 0.
  - The edge on which all FIFOs are empty and the counter equals IDLE_WAIT-1 moves to IDLE. ACTIVE->IDLE therefore needs exactly IDLE_WAIT consecutive all-empty sampled cycles in ACTIVE.
  - The counter clears on any exit from ACTIVE.
- ERROR:
  - Sticky: every edge in ERROR, error_src <= error_src | fifo_error.
  - On entry to ERROR, error_src <= fifo_error, OR-ed with any existing content.
  - Leaves only on init=1 -> INIT (error_src clears in INIT) or on reset.
  - fifo_error deasserting does not leave ERROR.
- Simultaneous events:
  - fifo_error with init in IDLE or ACTIVE: error wins.
  - fifo_error with the last drain cycle: error wins.
  - init while in ERROR: INIT wins.

Test Plan:
1. Reset and init load. Stimulus: reset=1 for 3 clocks, deassert; init=1, umbral_in=20'h1_2_3_4_5 for 2 clocks; init=0. Required:
   - state 0 during reset, then INIT;
   - umbrales_out=20'h12345 after INIT;
   - state=IDLE, idle=1 one edge after init=0;
   - changing umbral_in to 20'hFFFFF while in IDLE leaves umbrales_out=20'h12345.
2. Activity and drain hysteresis (IDLE_WAIT=2). Stimulus: from IDLE, fifo_empty=5'b11110; then 5'b11111 for 1 clock, 5'b11101 for 1 clock, 5'b11111 for 2 clocks. Required:
   - ACTIVE, active=1 on first edge;
   - the single empty cycle does not exit;
   - IDLE reached on the 2nd consecutive all-empty edge.
3. Sticky error. Stimulus: in ACTIVE, fifo_error=5'b10100 for 1 clock, then 5'b00001 for 1 clock, then 0 for 5 clocks. Required:
   - ERROR, error=1;
   - error_src=5'b10101 and held;
   - state stays ERROR throughout.
4. Error recovery and priority. Stimulus: in ERROR, init=1 with fifo_error=5'b00100 for 1 clock. Required:
   - INIT on the next edge;
   - error_src=0 one edge later;
   - in IDLE, init=1 together with fifo_error=5'b00010 -> ERROR, not INIT.
5. Async reset mid-operation. Stimulus: in ACTIVE with drain counter=1, pulse reset between clock edges. Required:
   - immediately (before the next edge) state=0, all outputs 0, umbrales_out=0;
   - INIT follows the first edge after release.

Source files
------------

// File: rtl/fsm_ctrl_multi.sv
// Flow-control FSM for the switch datapath: loads per-FIFO thresholds in INIT,
// tracks FIFO activity with drain hysteresis, and latches error sources.
module fsm_ctrl_multi #(
  parameter int NUM_FIFOS = 5,
  parameter int UMB_W     = 4,
  parameter int IDLE_WAIT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [NUM_FIFOS*UMB_W-1:0] umbral_in,
  input  logic [NUM_FIFOS-1:0]       fifo_error,
  input  logic [NUM_FIFOS-1:0]       fifo_empty,
  output logic [NUM_FIFOS*UMB_W-1:0] umbrales_out,
  output logic                       active,
  output logic                       idle,
  output logic                       error,
  output logic [NUM_FIFOS-1:0]       error_src,
  output logic [2:0]                 state
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam int              CNT_W    = $clog2(IDLE_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_WAIT - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_FIFOS-1:0] src_q, src_d;
  logic                 any_err;
  logic                 all_empty;

  assign any_err   = |fifo_error;
  assign all_empty = &fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT:  state_d = init ? S_INIT : S_IDLE;
      S_IDLE: begin
        if (any_err)         state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (!all_empty) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (any_err)        state_d = S_ERROR;
        else if (init)      state_d = S_INIT;
        else if (all_empty) begin
          // The IDLE_WAIT-th consecutive all-empty edge leaves; the counter
          // then drops back to zero together with the exit.
          if (cnt_q == CNT_LAST) state_d = S_IDLE;
          else                   cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_ERROR: state_d = init ? S_INIT : S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    src_d = src_q;
    if (state_q == S_INIT)
      src_d = '0;
    // Accumulate on entry, while resident, and on the edge that leaves ERROR.
    else if (state_q == S_ERROR || state_d == S_ERROR)
      src_d = src_q | fifo_error;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_umb
      logic [UMB_W-1:0] umb_q, umb_d;

      // Thresholds follow the input only while in INIT, locked otherwise.
      always_comb begin
        umb_d = umb_q;
        if (state_q == S_INIT)
          umb_d = umbral_in[gi*UMB_W +: UMB_W];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) umb_q <= '0;
        else       umb_q <= umb_d;
      end

      assign umbrales_out[gi*UMB_W +: UMB_W] = umb_q;
    end
  endgenerate

  assign active    = (state_q == S_ACTIVE);
  assign idle      = (state_q == S_IDLE);
  assign error     = (state_q == S_ERROR);
  assign error_src = src_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fsm_ctrl_multi.sv
// Scoreboard bench for fsm_ctrl_multi: each driven vector queues its expected
// post-edge state, and a monitor compares one entry after every rising edge.
module tb_fsm_ctrl_multi;
  localparam int N = 5;
  localparam int W = 4;
  localparam int IW = 2;
  localparam logic [N*W-1:0] U1 = 20'h12345;
  localparam logic [N*W-1:0] UF = 20'hFFFFF;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           init = 1'b0;
  logic [N*W-1:0] umbral_in = '0;
  logic [N-1:0]   fifo_error = '0;
  logic [N-1:0]   fifo_empty = '1;
  logic [N*W-1:0] umbrales_out;
  logic           active, idle, error;
  logic [N-1:0]   error_src;
  logic [2:0]     state;

  fsm_ctrl_multi #(.NUM_FIFOS(N), .UMB_W(W), .IDLE_WAIT(IW)) dut (
    .clk(clk), .reset(reset), .init(init), .umbral_in(umbral_in),
    .fifo_error(fifo_error), .fifo_empty(fifo_empty),
    .umbrales_out(umbrales_out), .active(active), .idle(idle),
    .error(error), .error_src(error_src), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    logic [2:0]     st;
    logic [N*W-1:0] umb;
    logic [N-1:0]   src;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st,
                           input logic [N*W-1:0] umb, input logic [N-1:0] src);
    check_val({tag, ".state"},  32'(state),        32'(st));
    check_val({tag, ".active"}, 32'(active),       32'(st == 3'd3));
    check_val({tag, ".idle"},   32'(idle),         32'(st == 3'd2));
    check_val({tag, ".error"},  32'(error),        32'(st == 3'd4));
    check_val({tag, ".umb"},    32'(umbrales_out), 32'(umb));
    check_val({tag, ".src"},    32'(error_src),    32'(src));
  endtask

  // Drive one vector mid-cycle and queue what must be visible after the next edge.
  task automatic step(input string tag, input logic rst_i, input logic init_i,
                      input logic [N*W-1:0] umb_i, input logic [N-1:0] err_i,
                      input logic [N-1:0] emp_i, input logic [2:0] st,
                      input logic [N*W-1:0] umb, input logic [N-1:0] src);
    exp_t e;
    @(negedge clk);
    reset      = rst_i;
    init       = init_i;
    umbral_in  = umb_i;
    fifo_error = err_i;
    fifo_empty = emp_i;
    e.tag = tag; e.st = st; e.umb = umb; e.src = src;
    exp_q.push_back(e);
    $display("vector %-6s rst=%b init=%b umb_in=%h err=%b emp=%b -> exp state=%0d umb=%h src=%b",
             tag, rst_i, init_i, umb_i, err_i, emp_i, st, umb, src);
  endtask

  // Async reset pulse between edges; effect must be visible before the next edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_all({tag, ".async"}, 3'd0, '0, '0);
    #1 reset = 1'b0;
    init = 1'b0;
    @(posedge clk);
    #2 check_all({tag, ".post"}, 3'd1, '0, '0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_all(e.tag, e.st, e.umb, e.src);
    end
  end

  initial begin
    // Reset held, then threshold load
    step("r0", 1, 0, U1, 5'b00000, 5'b11111, 3'd0, '0, '0);
    step("r1", 1, 0, U1, 5'b00000, 5'b11111, 3'd0, '0, '0);
    step("r2", 1, 0, U1, 5'b00000, 5'b11111, 3'd0, '0, '0);
    step("i1", 0, 1, U1, 5'b00000, 5'b11111, 3'd1, '0, '0);
    step("i2", 0, 1, U1, 5'b00000, 5'b11111, 3'd1, U1, '0);
    step("i3", 0, 0, U1, 5'b00000, 5'b11111, 3'd2, U1, '0);
    step("lock", 0, 0, UF, 5'b00000, 5'b11111, 3'd2, U1, '0);
    // Activity and drain hysteresis
    step("a1", 0, 0, UF, 5'b00000, 5'b11110, 3'd3, U1, '0);
    step("a2", 0, 0, UF, 5'b00000, 5'b11111, 3'd3, U1, '0);
    step("a3", 0, 0, UF, 5'b00000, 5'b11101, 3'd3, U1, '0);
    step("a4", 0, 0, UF, 5'b00000, 5'b11111, 3'd3, U1, '0);
    step("a5", 0, 0, UF, 5'b00000, 5'b11111, 3'd2, U1, '0);
    step("a6", 0, 0, UF, 5'b00000, 5'b11110, 3'd3, U1, '0);
    // Sticky error capture
    step("e1", 0, 0, UF, 5'b10100, 5'b11110, 3'd4, U1, 5'b10100);
    step("e2", 0, 0, UF, 5'b00001, 5'b11110, 3'd4, U1, 5'b10101);
    for (int i = 0; i < 5; i++)
      step($sformatf("e%0d", i + 3), 0, 0, UF, 5'b00000, 5'b11111, 3'd4, U1, 5'b10101);
    // Recovery via INIT, then error beats init in IDLE
    step("v1", 0, 1, UF, 5'b00100, 5'b11111, 3'd1, U1, 5'b10101);
    step("v2", 0, 0, UF, 5'b00000, 5'b11111, 3'd2, UF, '0);
    step("p1", 0, 1, UF, 5'b00010, 5'b11111, 3'd4, UF, 5'b00010);
    step("p2", 0, 1, UF, 5'b00000, 5'b11111, 3'd1, UF, 5'b00010);
    step("p3", 0, 0, U1, 5'b00000, 5'b11111, 3'd2, U1, '0);
    // Async reset with drain counter at 1
    step("d1", 0, 0, U1, 5'b00000, 5'b11110, 3'd3, U1, '0);
    step("d2", 0, 0, U1, 5'b00000, 5'b11111, 3'd3, U1, '0);
    pulse_reset("rstA");
    step("s1", 0, 0, UF, 5'b00000, 5'b11111, 3'd2, UF, '0);
    step("s2", 0, 0, UF, 5'b00000, 5'b11110, 3'd3, UF, '0);
    step("s3", 0, 0, UF, 5'b00000, 5'b11111, 3'd3, UF, '0);
    // Error on the last drain cycle wins over the IDLE transition
    step("s4", 0, 0, UF, 5'b01000, 5'b11111, 3'd4, UF, 5'b01000);
    step("s5", 0, 0, UF, 5'b00000, 5'b11111, 3'd4, UF, 5'b01000);
    pulse_reset("rstE");
    step("s6", 0, 0, UF, 5'b00000, 5'b11111, 3'd2, UF, '0);
    repeat (2) @(posedge clk);
    #2 check_val("drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
